// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the multicycle RISC-V control path: state encoding,
// opcodes, ALUOp codes, datapath mux selects and the ImmSrc decode helper.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Immediate format chosen purely from the opcode; unknown opcodes fall to I.
  function automatic logic [1:0] imm_src_decode(input logic [6:0] op);
    logic [1:0] imm;
    case (op)
      OP_LW, OP_I: imm = IMM_I;
      OP_SW:       imm = IMM_S;
      OP_BEQ:      imm = IMM_B;
      OP_JAL:      imm = IMM_J;
      default:     imm = IMM_I;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle controller and the shared datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [2:0]  ALUControl;
  logic        RegWrite;
  logic        IllegalOp;
  logic [31:0] RetireCount;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, IllegalOp, RetireCount
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, IllegalOp, RetireCount
  );
endinterface

// File: rtl/ALUDecoder.sv
// ALU operation decoder: maps ALUOp plus instruction function fields to
// the 3-bit ALUControl code.
module ALUDecoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       opcode_5,
  output logic [2:0] alu_control
);

  // Select the ALU function; only R-type with funct7b5 set turns 000 into sub
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000: begin
            if (opcode_5 & funct7b5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// Main sequencing FSM: state register, next-state logic and Moore outputs
// for the multicycle datapath. retire flags the states that end an
// instruction and always return to FETCH.
module main_fsm
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       branch,
  output logic       pc_update,
  output logic       illegal_op,
  output logic       retire,
  output logic [1:0] alu_op,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b
);

  state_t state_r;
  state_t next_state_s;

  // State register; reset parks the controller in FETCH without a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and per-state Moore outputs
  always_comb begin
    next_state_s = S_FETCH;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    branch       = 1'b0;
    pc_update    = 1'b0;
    illegal_op   = 1'b0;
    retire       = 1'b0;
    alu_op       = ALUOP_ADD;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    case (state_r)
      S_FETCH: begin
        ir_write     = 1'b1;
        alu_src_b    = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        pc_update    = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R:         next_state_s = S_EXECUTER;
          OP_I:         next_state_s = S_EXECUTEI;
          OP_BEQ:       next_state_s = S_BEQ;
          OP_JAL:       next_state_s = S_JAL;
          default: begin
            illegal_op   = 1'b1;
            next_state_s = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (op == OP_LW) begin
          next_state_s = S_MEMREAD;
        end else begin
          next_state_s = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        adr_src      = 1'b1;
        next_state_s = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = RES_DATA;
        reg_write    = 1'b1;
        retire       = 1'b1;
        next_state_s = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src      = 1'b1;
        mem_write    = 1'b1;
        retire       = 1'b1;
        next_state_s = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a    = SRCA_RS1;
        alu_op       = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a    = SRCA_RS1;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALUOP_FUNCT;
        next_state_s = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write    = 1'b1;
        retire       = 1'b1;
        next_state_s = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a    = SRCA_RS1;
        alu_op       = ALUOP_SUB;
        branch       = 1'b1;
        retire       = 1'b1;
        next_state_s = S_FETCH;
      end
      S_JAL: begin
        // JAL routes OldPC + 4 to ALUWB so rd receives the link address
        alu_src_a    = SRCA_OLDPC;
        alu_src_b    = SRCB_FOUR;
        pc_update    = 1'b1;
        next_state_s = S_ALUWB;
      end
      default: next_state_s = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V controller top: main FSM, ALU decoder, ImmSrc decode,
// PCWrite combine, enable gating during reset and the retire counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  multicycle_controller_if.master bus
);

  logic        adr_src_s;
  logic        mem_write_s;
  logic        ir_write_s;
  logic        reg_write_s;
  logic        branch_s;
  logic        pc_update_s;
  logic        illegal_op_s;
  logic        retire_s;
  logic [1:0]  alu_op_s;
  logic [1:0]  result_src_s;
  logic [1:0]  alu_src_a_s;
  logic [1:0]  alu_src_b_s;
  logic [2:0]  alu_control_s;
  logic [31:0] retire_count_r;

  main_fsm u_main_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (bus.op),
    .adr_src    (adr_src_s),
    .mem_write  (mem_write_s),
    .ir_write   (ir_write_s),
    .reg_write  (reg_write_s),
    .branch     (branch_s),
    .pc_update  (pc_update_s),
    .illegal_op (illegal_op_s),
    .retire     (retire_s),
    .alu_op     (alu_op_s),
    .result_src (result_src_s),
    .alu_src_a  (alu_src_a_s),
    .alu_src_b  (alu_src_b_s)
  );

  ALUDecoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .opcode_5    (bus.op[5]),
    .alu_control (alu_control_s)
  );

  // Drive the bus; write enables are held off while reset is asserted so an
  // interrupted instruction can never leave a partial write behind
  always_comb begin
    bus.PCWrite     = rst_n & (pc_update_s | (branch_s & bus.Zero));
    bus.IRWrite     = rst_n & ir_write_s;
    bus.MemWrite    = rst_n & mem_write_s;
    bus.RegWrite    = rst_n & reg_write_s;
    bus.AdrSrc      = adr_src_s;
    bus.ResultSrc   = result_src_s;
    bus.ALUSrcA     = alu_src_a_s;
    bus.ALUSrcB     = alu_src_b_s;
    bus.ImmSrc      = imm_src_decode(bus.op);
    bus.ALUControl  = alu_control_s;
    bus.IllegalOp   = illegal_op_s;
    bus.RetireCount = retire_count_r;
  end

  // Retired-instruction counter; wraps naturally at 32 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count_r <= 32'd0;
    end else if (retire_s) begin
      retire_count_r <= retire_count_r + 32'd1;
    end else begin
      retire_count_r <= retire_count_r;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus process pushes the
// expected per-cycle control word of each instruction; a monitor pops and
// compares on every falling clock edge while out of reset.
module tb_multicycle_controller;

  localparam logic [6:0] T_LW  = 7'b0000011;
  localparam logic [6:0] T_SW  = 7'b0100011;
  localparam logic [6:0] T_R   = 7'b0110011;
  localparam logic [6:0] T_I   = 7'b0010011;
  localparam logic [6:0] T_BEQ = 7'b1100011;
  localparam logic [6:0] T_JAL = 7'b1101111;

  typedef enum {PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMREAD, PH_MEMWB, PH_MEMWRITE,
                PH_EXECUTER, PH_EXECUTEI, PH_ALUWB, PH_BEQ, PH_JAL} ph_t;
  typedef ph_t ph_q_t[$];

  typedef struct {
    string       name;
    logic        pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0]  result_src, src_a, src_b, imm_src;
    logic [2:0]  alu_ctl;
    logic [31:0] retire;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic [31:0] model_retire = 32'd0;

  always #5 clk = ~clk;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL};
  endfunction

  // Phase sequence each instruction class walks through
  function automatic ph_q_t phases_for(input logic [6:0] op);
    ph_q_t q;
    q.push_back(PH_FETCH);
    q.push_back(PH_DECODE);
    case (op)
      T_LW:  begin q.push_back(PH_MEMADR); q.push_back(PH_MEMREAD); q.push_back(PH_MEMWB); end
      T_SW:  begin q.push_back(PH_MEMADR); q.push_back(PH_MEMWRITE); end
      T_R:   begin q.push_back(PH_EXECUTER); q.push_back(PH_ALUWB); end
      T_I:   begin q.push_back(PH_EXECUTEI); q.push_back(PH_ALUWB); end
      T_BEQ: q.push_back(PH_BEQ);
      T_JAL: begin q.push_back(PH_JAL); q.push_back(PH_ALUWB); end
      default: ;
    endcase
    return q;
  endfunction

  // ALU function an R/I instruction asks for
  function automatic logic [2:0] ref_funct_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected control word for one phase of an instruction
  function automatic exp_t mk(input ph_t p, input logic [6:0] op, input logic [2:0] f3,
                              input logic f7, input logic z, input logic [31:0] ret);
    exp_t e;
    e.name       = p.name();
    e.pc_write   = (p inside {PH_FETCH, PH_JAL}) || (p == PH_BEQ && z);
    e.adr_src    = p inside {PH_MEMREAD, PH_MEMWRITE};
    e.mem_write  = (p == PH_MEMWRITE);
    e.ir_write   = (p == PH_FETCH);
    e.reg_write  = p inside {PH_MEMWB, PH_ALUWB};
    e.illegal    = (p == PH_DECODE) && !is_legal(op);
    e.result_src = (p == PH_FETCH) ? 2'b10 : (p == PH_MEMWB) ? 2'b01 : 2'b00;
    e.src_a      = (p inside {PH_MEMADR, PH_EXECUTER, PH_EXECUTEI, PH_BEQ}) ? 2'b10 :
                   (p inside {PH_DECODE, PH_JAL}) ? 2'b01 : 2'b00;
    e.src_b      = (p inside {PH_FETCH, PH_JAL}) ? 2'b10 :
                   (p inside {PH_DECODE, PH_MEMADR, PH_EXECUTEI}) ? 2'b01 : 2'b00;
    e.imm_src    = (op == T_SW) ? 2'b01 : (op == T_BEQ) ? 2'b10 : (op == T_JAL) ? 2'b11 : 2'b00;
    e.alu_ctl    = (p inside {PH_EXECUTER, PH_EXECUTEI}) ? ref_funct_alu(op, f3, f7) :
                   (p == PH_BEQ) ? 3'b001 : 3'b000;
    e.retire     = ret;
    return e;
  endfunction

  // Monitor: compare the DUT control word against the scoreboard each cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty: DUT cycle with no expectation (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, ".PCWrite"},     32'(bus.PCWrite),     32'(e.pc_write));
        chk({e.name, ".AdrSrc"},      32'(bus.AdrSrc),      32'(e.adr_src));
        chk({e.name, ".MemWrite"},    32'(bus.MemWrite),    32'(e.mem_write));
        chk({e.name, ".IRWrite"},     32'(bus.IRWrite),     32'(e.ir_write));
        chk({e.name, ".RegWrite"},    32'(bus.RegWrite),    32'(e.reg_write));
        chk({e.name, ".IllegalOp"},   32'(bus.IllegalOp),   32'(e.illegal));
        chk({e.name, ".ResultSrc"},   32'(bus.ResultSrc),   32'(e.result_src));
        chk({e.name, ".ALUSrcA"},     32'(bus.ALUSrcA),     32'(e.src_a));
        chk({e.name, ".ALUSrcB"},     32'(bus.ALUSrcB),     32'(e.src_b));
        chk({e.name, ".ImmSrc"},      32'(bus.ImmSrc),      32'(e.imm_src));
        chk({e.name, ".ALUControl"},  32'(bus.ALUControl),  32'(e.alu_ctl));
        chk({e.name, ".RetireCount"}, bus.RetireCount,      e.retire);
      end
    end
  end

  // Issue one instruction; zmode 0/1 fixes Zero, 2 randomises it per cycle.
  // ncyc < 0 runs the whole instruction, otherwise only that many cycles.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int zmode, input int ncyc);
    ph_q_t seq;
    logic  zs[$];
    logic  z;
    int    n;
    seq = phases_for(op);
    bus.op       = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    n = (ncyc < 0) ? seq.size() : ncyc;
    for (int i = 0; i < n; i++) begin
      z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
      zs.push_back(z);
      exp_q.push_back(mk(seq[i], op, f3, f7, z, model_retire));
    end
    if (ncyc < 0 && is_legal(op)) model_retire = model_retire + 32'd1;
    for (int i = 0; i < n; i++) begin
      bus.Zero = zs[i];
      @(negedge clk);
      if (i != n - 1 || ncyc < 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  // Reset asserted mid-MEMWRITE of a store
  task automatic reset_mid_sw();
    run_instr(T_SW, 3'b010, 1'b0, 0, 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst.MemWrite",    32'(bus.MemWrite), 32'd0);
    chk("rst.RetireCount", bus.RetireCount,   32'd0);
    chk("rst.IRWrite",     32'(bus.IRWrite),  32'd0);
    chk("rst.PCWrite",     32'(bus.PCWrite),  32'd0);
    chk("rst.RegWrite",    32'(bus.RegWrite), 32'd0);
    chk("rst.ALUSrcB",     32'(bus.ALUSrcB),  32'd2);
    chk("rst.ResultSrc",   32'(bus.ResultSrc), 32'd2);
    model_retire = 32'd0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel.IRWrite",  32'(bus.IRWrite),  32'd1);
    chk("rel.MemWrite", 32'(bus.MemWrite), 32'd0);
  endtask

  initial begin
    logic [6:0] op;
    int         sel;
    bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("por.RetireCount", bus.RetireCount,  32'd0);
    chk("por.IRWrite",     32'(bus.IRWrite), 32'd0);
    chk("por.PCWrite",     32'(bus.PCWrite), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("por_rel.IRWrite", 32'(bus.IRWrite), 32'd1);

    run_instr(T_LW,  3'b010, 1'b0, 2, -1);
    run_instr(T_R,   3'b000, 1'b1, 2, -1);   // sub
    run_instr(T_R,   3'b111, 1'b0, 2, -1);   // and
    reset_mid_sw();
    run_instr(T_BEQ, 3'b000, 1'b0, 1, -1);   // taken
    run_instr(T_BEQ, 3'b000, 1'b0, 0, -1);   // not taken
    run_instr(T_JAL, 3'b000, 1'b0, 2, -1);
    run_instr(T_SW,  3'b010, 1'b0, 2, -1);
    run_instr(7'b1111111, 3'b000, 1'b0, 2, -1);

    for (int k = 0; k < 60; k++) begin
      sel = int'($urandom_range(0, 7));
      case (sel)
        0: op = T_LW;
        1: op = T_SW;
        2: op = T_R;
        3: op = T_I;
        4: op = T_BEQ;
        5: op = T_JAL;
        6: op = 7'($urandom);
        default: op = 7'b1111111;
      endcase
      run_instr(op, 3'($urandom), 1'($urandom), 2, -1);
    end

    // Counter wrap: preload all ones, retire one add, then one more instruction
    force dut.retire_count_r = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_r;
    model_retire = 32'hFFFF_FFFF;
    run_instr(T_R, 3'b000, 1'b0, 2, -1);
    run_instr(T_I, 3'b110, 1'b1, 2, -1);
    chk("wrap.RetireCount", bus.RetireCount, model_retire);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle RISC-V core. It replaces the single-cycle control path with a Moore state machine that steps the shared datapath (one ALU, one memory port, one instruction register) through fetch, decode, execute, memory and writeback across several cycles. It drives the ALU through the existing ALUDecoder, produces every datapath enable and mux select, and keeps a retired-instruction counter.

## Interface
- No parameters. Opcodes and state encodings are fixed constants.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0], from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- Zero  in  1  ALU zero flag
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write enable
- IRWrite  out  1  instruction/OldPC register enable
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  ALU B mux: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- ALUControl  out  3  from ALUDecoder
- RegWrite  out  1  register file write enable
- IllegalOp  out  1  high in DECODE when op is unsupported
- RetireCount  out  32  number of retired instructions

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- **Output style:** all outputs are Moore, except two that are combinational on op or Zero.
  - PCWrite = PCUpdate | (Branch & Zero).
  - ImmSrc is decoded from op in every state: lw and I-type 00, sw 01, beq 10, jal 11, other opcodes 00.
- **Outputs per state.** Any signal not listed is 0 (selects 00).
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp 00, ResultSrc 10, PCUpdate 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp 00 (computes the branch/jump target).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp 00.
  - MEMREAD: AdrSrc 1, ResultSrc 00.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: AdrSrc 1, ResultSrc 00, MemWrite 1.
  - EXECUTER: ALUSrcA 10, ALUSrcB 00, ALUOp 10.
  - EXECUTEI: ALUSrcA 10, ALUSrcB 01, ALUOp 10.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp 01, ResultSrc 00, Branch 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp 00, ResultSrc 00, PCUpdate 1.
- **Transitions:**
  - FETCH goes to DECODE.
  - DECODE branches on op:
    - 0000011 or 0100011 go to MEMADR.
    - 0110011 goes to EXECUTER.
    - 0010011 goes to EXECUTEI.
    - 1100011 goes to BEQ.
    - 1101111 goes to JAL.
    - Any other opcode goes to FETCH with IllegalOp = 1 for that cycle.
  - MEMADR goes to MEMREAD if op = 0000011, otherwise to MEMWRITE.
  - MEMREAD goes to MEMWB; MEMWB goes to FETCH.
  - MEMWRITE goes to FETCH.
  - EXECUTER and EXECUTEI go to ALUWB.
  - JAL goes to ALUWB (writes PC+4 to rd).
  - ALUWB and BEQ go to FETCH.
- **ALUControl:** the existing ALUDecoder is instantiated with ALUOp, funct3, funct7b5, and op[5] as opcode_5.
- **Retire counter:** RetireCount increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ.
  - An illegal-op return from DECODE does not increment it.
  - The counter wraps from 0xFFFFFFFF to 0.
- **Undefined state:** an unreachable encoding goes to FETCH on the next clock.

## Timing
- **Reset:** rst_n low forces the state to FETCH and RetireCount to 0 immediately, with no clock needed.
- **Enable gating:** while rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0. Mux selects show FETCH values.
- **First fetch:** the first active FETCH edge is the first rising clk after rst_n deasserts.
- **Reset mid-instruction:** the instruction is abandoned and no partial write occurs after reset assertion.
- **Cycles per instruction (FETCH through last state):** lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- **Input stability:** op, funct3 and funct7b5 are sampled only from DECODE onward. They are stable because IRWrite is asserted only in FETCH.
- **Zero:** evaluated combinationally in BEQ. Taken branch means PCWrite is high in BEQ only.
- **RetireCount:** updates on the same edge as the state change into FETCH.

## Structure
- Package riscv_ctrl_pkg holds:
  - state encoding constants (4-bit, FETCH = 0 through JAL = 10);
  - opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - ALUOp codes;
  - ResultSrc, ALUSrcA and ALUSrcB codes.
- Sub-module main_fsm holds the state register, next-state logic and Moore outputs (including ALUOp, Branch, PCUpdate).
- The top level contains main_fsm, ALUDecoder, the ImmSrc decode, PCWrite logic, the reset gating and RetireCount.

## Test plan
- **Reset:** rst_n low mid-MEMWRITE.
  - Expect MemWrite = 0 and RetireCount = 0 immediately.
  - After release, expect state FETCH with IRWrite = 1.
- **lw:** op = 0000011, funct3 = 010.
  - Expect the state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
  - Expect RegWrite = 1 only in MEMWB, ResultSrc = 01, ALUControl = 000 in MEMADR, RetireCount = 1.
- **sub then and:**
  - op = 0110011, funct3 = 000, funct7b5 = 1: ALUControl = 001 in EXECUTER.
  - funct3 = 111: ALUControl = 010.
  - Expect 4 cycles per instruction and RetireCount = 2.
- **beq:** op = 1100011.
  - Zero = 1 in BEQ: PCWrite = 1 in BEQ.
  - Zero = 0: PCWrite = 0.
  - ImmSrc = 10 and ALUControl = 001 in BEQ; 3 cycles.
- **jal and sw:**
  - jal goes FETCH, DECODE, JAL, ALUWB, with PCWrite = 1 in JAL and ImmSrc = 11.
  - sw goes to MEMWRITE, with MemWrite = 1 for exactly one cycle and ImmSrc = 01.
- **Illegal opcode and counter wrap:**
  - op = 1111111: IllegalOp = 1 in DECODE, then FETCH; RetireCount unchanged.
  - Force RetireCount to 0xFFFFFFFF, then retire one add: RetireCount = 0.
